// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, arbiter state encoding and index-width helper.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN
   } arb_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority select: first set request at or after ptr, wrapping, as one-hot plus index.
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             any
);

   logic [2*N_REQ-1:0] rot;
   int unsigned        pos;

   always_comb begin
      rot = {req, req} >> ptr;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!any && rot[i]) begin
            any = 1'b1;
            pos = 32'(ptr) + i;
            if (pos >= N_REQ) pos = pos - N_REQ;
            idx = IW'(pos);
         end
      end
      if (any) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among N_REQ byte producers, with message locking
// and an accept timeout when the transmitter never takes the byte.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int N_REQ          = 4,
   parameter  int ACCEPT_TIMEOUT = 16,
   localparam int IW             = idx_w(N_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [UART_DATA_W*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]             req_last,
   output logic [N_REQ-1:0]             req_ready,
   input  logic                         uart_rdy,
   output logic [UART_DATA_W-1:0]       uart_data,
   output logic                         uart_write_en,
   output logic [IW-1:0]                grant_id,
   output logic                         busy,
   output logic                         err_timeout
);

   localparam int CW = $clog2(ACCEPT_TIMEOUT + 1);

   arb_state_t             state_q, state_d;
   logic                   lock_q, lock_d;
   logic                   last_q, last_d;
   logic [IW-1:0]          rr_ptr, ptr_d, ptr_next;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [UART_DATA_W-1:0] data_d;
   logic [IW-1:0]          gid_d;
   logic                   err_d;

   logic [N_REQ-1:0]       owner_mask, eligible, pick_gnt;
   logic [IW-1:0]          pick_idx;
   logic                   pick_any;

   rr_picker #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_picker (
      .req (eligible),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      owner_mask = '1;
      if (lock_q) begin
         owner_mask           = '0;
         owner_mask[grant_id] = 1'b1;
      end
      eligible = (state_q == IDLE && uart_rdy) ? (req_valid & owner_mask) : '0;
      if (N_REQ == 1 || grant_id == IW'(N_REQ - 1)) ptr_next = '0;
      else                                          ptr_next = grant_id + 1'b1;
   end

   assign req_ready     = rst ? '0 : pick_gnt;
   assign uart_write_en = (state_q == LOAD);
   assign busy          = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      last_d  = last_q;
      ptr_d   = rr_ptr;
      cnt_d   = cnt_q;
      data_d  = uart_data;
      gid_d   = grant_id;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               data_d  = req_data[int'(pick_idx)*UART_DATA_W +: UART_DATA_W];
               gid_d   = pick_idx;
               last_d  = req_last[pick_idx];
               cnt_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (!uart_rdy) begin
               state_d = DRAIN;
            end else if (cnt_q == CW'(ACCEPT_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               lock_d  = 1'b0;
               ptr_d   = ptr_next;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (uart_rdy) begin
               state_d = IDLE;
               // Pointer stays on a locked owner so it regains the line first.
               if (last_q) begin
                  lock_d = 1'b0;
                  ptr_d  = ptr_next;
               end else begin
                  lock_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lock_q      <= 1'b0;
         last_q      <= 1'b0;
         rr_ptr      <= '0;
         cnt_q       <= '0;
         uart_data   <= '0;
         grant_id    <= '0;
         err_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         lock_q      <= lock_d;
         last_q      <= last_d;
         rr_ptr      <= ptr_d;
         cnt_q       <= cnt_d;
         uart_data   <= data_d;
         grant_id    <= gid_d;
         err_timeout <= err_d;
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares one `uart_tx` transmitter among `N_REQ` byte producers. It captures one byte at a time over a valid/ready handshake and drives the transmitter's `data`/`write_en` pair. It releases `write_en` once the transmitter drops `rdy`, then waits for the frame to finish before granting again. Optional message locking keeps multi-byte messages from different requesters from interleaving on the line.

## Interface
- `N_REQ`, 4: number of requesters, 1..8.
- `ACCEPT_TIMEOUT`, 16: cycles `uart_write_en` may stay high without `uart_rdy` falling before the byte is dropped.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `N_REQ`: requester i has a byte.
- `req_data` in `8*N_REQ`: byte i is bits `[8i+7:8i]`.
- `req_last` in `N_REQ`: byte i ends its message; 0 requests a lock.
- `req_ready` out `N_REQ`: one-hot; byte i is captured when `req_valid[i] & req_ready[i]`.
- `uart_rdy` in 1: transmitter idle, from `uart_tx.rdy`.
- `uart_data` out 8: to `uart_tx.data`.
- `uart_write_en` out 1: to `uart_tx.write_en`.
- `grant_id` out `max(1,$clog2(N_REQ))`: owner of the current or last byte.
- `busy` out 1: state is not IDLE.
- `err_timeout` out 1: one-cycle pulse when a byte is dropped.

## Operation
- States: IDLE, LOAD, DRAIN.
- IDLE, no lock:
  - Eligible = `req_valid` when `uart_rdy`=1.
  - Winner = first set index at or after `rr_ptr`, wrapping.
  - `req_ready[winner]`=1 combinationally in the same cycle.
  - At the edge, register `uart_data`, `grant_id`, `last_q`; go to LOAD.
- IDLE, locked: only `grant_id` is eligible; other requesters stall even if valid. If the owner has no valid byte, remain in IDLE.
- LOAD:
  - `uart_write_en`=1 and `uart_data` held stable.
  - `uart_rdy`=0 seen: go to DRAIN and drop `uart_write_en`.
  - Timeout counter reaches `ACCEPT_TIMEOUT`: pulse `err_timeout`, drop `uart_write_en`, clear lock, advance `rr_ptr`, go to IDLE.
- DRAIN: `uart_write_en`=0. When `uart_rdy`=1, go to IDLE.
- Lock and pointer update on leaving DRAIN:
  - `last_q`=1: lock cleared, `rr_ptr` = `grant_id`+1 mod `N_REQ`.
  - `last_q`=0: lock set, `rr_ptr` unchanged.
- `uart_data` holds its last value between transfers and is never cleared except by reset.
- `N_REQ`=1: pointer is constant 0; locking still gates nothing else.

## Timing
- Reset values: `uart_write_en`=0, `uart_data`=0, `grant_id`=0, `busy`=0, `err_timeout`=0, `req_ready`=0 (forced during `rst`), `rr_ptr`=0, lock=0, state IDLE.
- Capture at edge t. `uart_write_en` and `uart_data` are valid from t+1, so capture-to-write_en latency is 1 cycle.
- At most one capture per frame.
- `req_ready` is never asserted outside IDLE or while `uart_rdy`=0.
- `uart_write_en` falls on the edge after `uart_rdy` is sampled 0. The transmitter has already latched the byte by then, so no duplicate frame is started.
- Timeout counter:
  - Clears on entry to LOAD and counts each LOAD cycle.
  - `err_timeout` fires in the cycle after count = `ACCEPT_TIMEOUT`-1.
- Reset mid-frame:
  - Outputs return to reset values at the next edge.
  - The in-flight serial frame completes on the line, since `uart_tx` itself has no reset.
  - The arbiter grants no new byte until `uart_rdy`=1.
- Simultaneous valid: round-robin order decides. `req_last` is sampled only at capture.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W`=8.
  - State enum `arb_state_t` {IDLE, LOAD, DRAIN}.
  - Used also by `uart_tx`/`uart_rx` wrappers.
- Sub-module `rr_picker`:
  - Combinational rotate-priority-select.
  - Inputs: `N_REQ`-bit request vector and pointer.
  - Outputs: one-hot grant and encoded index.
- Top level: FSM, timeout counter, lock/pointer registers, data mux.

## Test plan
All scenarios use the real `uart_tx` with `N_REQ`=4 unless noted.
- **Single byte:** after reset, requester 2 valid with 0x55, last=1.
  - `req_ready`=0100 for exactly 1 cycle.
  - `uart_write_en` high the next cycle.
  - Line carries start, 1,0,1,0,1,0,1,0 LSB first, then stop.
  - `grant_id`=2, `rr_ptr`=3 afterwards.
- **Fairness:** all four valid continuously, each last=1. Grant order is 0,1,2,3,0, with one capture per frame and no frame overlap.
- **Lock:** requester 1 sends 0xA1 (last=0) then 0xA2 (last=1) while requester 0 is valid. Line order is A1, A2, then requester 0's byte.
- **Timeout:** stub `uart_rdy` stuck at 1 with `ACCEPT_TIMEOUT`=16.
  - `err_timeout` pulses once, 16 cycles after `uart_write_en` rises.
  - `uart_write_en`=0 the next cycle, lock cleared.
- **Reset mid-frame:** assert `rst` during data bit 3.
  - All outputs at reset values next cycle.
  - No capture until `uart_rdy` returns to 1.
  - The next byte is transmitted intact.
- **N_REQ=1:** back-to-back bytes 0x00, 0xFF transmit in order. `grant_id` is always 0.
